// File: rtl/encode_ir_if.sv
`default_nettype none
// ============================================================================
//  Module      : encode_ir_if
//  Description : Host-side command and emitter bundle for the NEC IR
//                transmitter. The host drives the payload and frame
//                requests; the transmitter returns status and both line
//                outputs.
//                  data   [31:0] frame payload, sampled on accept
//                  send          request a data frame (level)
//                  rep           request a repeat frame (level)
//                  busy          frame in progress
//                  done          one-cycle pulse at frame completion
//                  ir_out        demodulated line, 0 = mark
//                  ir_led        38 kHz modulated emitter drive
//                  led    [2:0]  current state code, debug only
//  Revision    : 1.0  initial release
// ============================================================================
interface encode_ir_if;
    logic [31:0] data;
    logic        send;
    logic        rep;
    logic        busy;
    logic        done;
    logic        ir_out;
    logic        ir_led;
    logic [2:0]  led;

    modport master (
        output data, send, rep,
        input  busy, done, ir_out, ir_led, led
    );

    modport slave (
        input  data, send, rep,
        output busy, done, ir_out, ir_led, led
    );
endinterface
`default_nettype wire

// File: rtl/encode_ir.sv
`default_nettype none
// ============================================================================
//  Module      : encode_ir
//  Description : NEC pulse-distance IR transmitter. Serialises a 32-bit word
//                (MSB first) or a repeat code into the NEC mark/space
//                waveform. Timing assumes a 1 MHz clock (1 cycle = 1 us).
//  Ports       : clk    system clock
//                rst_n  asynchronous active-low reset
//                bus    encode_ir_if.slave
//                         in : data[31:0], send, rep
//                         out: busy, done, ir_out, ir_led, led[2:0]
//  Revision    : 1.0  initial release
// ============================================================================
module encode_ir #(
    parameter int unsigned T_LEAD_MARK  = 9000,
    parameter int unsigned T_LEAD_SPACE = 4500,
    parameter int unsigned T_REP_SPACE  = 2250,
    parameter int unsigned T_BIT_MARK   = 562,
    parameter int unsigned T_ZERO_SPACE = 562,
    parameter int unsigned T_ONE_SPACE  = 1687,
    parameter int unsigned T_GUARD      = 6000,
    parameter int unsigned CARRIER_DIV  = 26,
    parameter int unsigned CARRIER_HIGH = 9
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    encode_ir_if.slave  bus
);

    // State codes are visible on led, so the values are fixed.
    localparam logic [2:0] c_st_idle       = 3'd0;
    localparam logic [2:0] c_st_lead_mark  = 3'd1;
    localparam logic [2:0] c_st_lead_space = 3'd2;
    localparam logic [2:0] c_st_bit_mark   = 3'd3;
    localparam logic [2:0] c_st_bit_space  = 3'd4;
    localparam logic [2:0] c_st_stop_mark  = 3'd5;
    localparam logic [2:0] c_st_guard      = 3'd6;

    // Terminal counts: a segment of N cycles ends when the counter hits N-1.
    localparam logic [13:0] c_lead_mark_end  = 14'(T_LEAD_MARK - 1);
    localparam logic [13:0] c_lead_space_end = 14'(T_LEAD_SPACE - 1);
    localparam logic [13:0] c_rep_space_end  = 14'(T_REP_SPACE - 1);
    localparam logic [13:0] c_bit_mark_end   = 14'(T_BIT_MARK - 1);
    localparam logic [13:0] c_zero_space_end = 14'(T_ZERO_SPACE - 1);
    localparam logic [13:0] c_one_space_end  = 14'(T_ONE_SPACE - 1);
    localparam logic [13:0] c_guard_end      = 14'(T_GUARD - 1);

    localparam int                 c_car_w    = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;
    localparam logic [c_car_w-1:0] c_car_last = c_car_w'(CARRIER_DIV - 1);
    localparam logic [c_car_w-1:0] c_car_high = c_car_w'(CARRIER_HIGH);

    logic [2:0]         r_state;
    logic [13:0]        r_cnt;
    logic [31:0]        r_sreg;
    logic [4:0]         r_idx;
    logic               r_rep;
    logic [c_car_w-1:0] r_car;

    logic               r_busy;
    logic               r_done;
    logic               r_ir_out;
    logic               r_ir_led;
    logic [2:0]         r_led;

    logic [13:0]        w_dur_end;
    logic               w_seg_done;
    logic               w_is_mark;
    logic               w_next_is_mark;
    logic               w_state_change;
    logic [2:0]         w_next_state;

    // Length of the segment currently being timed.
    always_comb begin
        w_dur_end = 14'd0;
        case (r_state)
            c_st_lead_mark:  w_dur_end = c_lead_mark_end;
            c_st_lead_space: w_dur_end = r_rep ? c_rep_space_end : c_lead_space_end;
            c_st_bit_mark:   w_dur_end = c_bit_mark_end;
            c_st_bit_space:  w_dur_end = r_sreg[31] ? c_one_space_end : c_zero_space_end;
            c_st_stop_mark:  w_dur_end = c_bit_mark_end;
            c_st_guard:      w_dur_end = c_guard_end;
            default:         w_dur_end = 14'd0;
        endcase
    end

    assign w_seg_done = (r_cnt == w_dur_end);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (bus.send || bus.rep) begin
                    w_next_state = c_st_lead_mark;
                end
            end
            c_st_lead_mark: begin
                if (w_seg_done) begin
                    w_next_state = c_st_lead_space;
                end
            end
            c_st_lead_space: begin
                if (w_seg_done) begin
                    w_next_state = r_rep ? c_st_stop_mark : c_st_bit_mark;
                end
            end
            c_st_bit_mark: begin
                if (w_seg_done) begin
                    w_next_state = c_st_bit_space;
                end
            end
            c_st_bit_space: begin
                if (w_seg_done) begin
                    w_next_state = (r_idx == 5'd31) ? c_st_stop_mark : c_st_bit_mark;
                end
            end
            c_st_stop_mark: begin
                if (w_seg_done) begin
                    w_next_state = c_st_guard;
                end
            end
            c_st_guard: begin
                if (w_seg_done) begin
                    w_next_state = c_st_idle;
                end
            end
            default: w_next_state = c_st_idle;
        endcase
    end

    assign w_is_mark      = (r_state == c_st_lead_mark) || (r_state == c_st_bit_mark) ||
                            (r_state == c_st_stop_mark);
    assign w_next_is_mark = (w_next_state == c_st_lead_mark) || (w_next_state == c_st_bit_mark) ||
                            (w_next_state == c_st_stop_mark);
    assign w_state_change = (w_next_state != r_state);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_st_idle;
            r_cnt    <= 14'd0;
            r_sreg   <= 32'd0;
            r_idx    <= 5'd0;
            r_rep    <= 1'b0;
            r_car    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_ir_out <= 1'b1;
            r_ir_led <= 1'b0;
            r_led    <= 3'd0;
        end else begin
            r_state <= w_next_state;

            // Shared duration counter restarts on every state entry.
            if (w_state_change) begin
                r_cnt <= 14'd0;
            end else if (r_state != c_st_idle) begin
                r_cnt <= r_cnt + 14'd1;
            end

            // Request capture; send wins over rep.
            if (r_state == c_st_idle) begin
                if (bus.send) begin
                    r_sreg <= bus.data;
                    r_rep  <= 1'b0;
                end else if (bus.rep) begin
                    r_rep  <= 1'b1;
                end
            end

            if ((r_state == c_st_lead_space) && w_seg_done) begin
                r_idx <= 5'd0;
            end

            // Next bit is always presented at the shift-register MSB.
            if ((r_state == c_st_bit_space) && w_seg_done) begin
                r_sreg <= {r_sreg[30:0], 1'b0};
                r_idx  <= r_idx + 5'd1;
            end

            // Carrier phase restarts on each mark so every mark opens high.
            if (w_state_change && w_next_is_mark) begin
                r_car <= '0;
            end else if (w_is_mark) begin
                r_car <= (r_car == c_car_last) ? '0 : r_car + 1'b1;
            end

            // Outputs trail the state by one cycle, uniformly.
            r_ir_out <= ~w_is_mark;
            r_ir_led <= w_is_mark && (r_car < c_car_high);
            r_busy   <= (r_state != c_st_idle);
            // IDLE is only ever entered from GUARD, so a busy-to-idle edge
            // marks frame completion.
            r_done   <= (r_state == c_st_idle) && r_busy;
            r_led    <= r_state;
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.ir_out = r_ir_out;
    assign bus.ir_led = r_ir_led;
    assign bus.led    = r_led;

endmodule
`default_nettype wire

// File: tb/tb_encode_ir.sv
`default_nettype none
// ============================================================================
//  Module      : tb_encode_ir
//  Description : Bench for encode_ir. Instance 0 uses the real NEC timing,
//                instance 1 a shortened timing set so full data frames fit.
//                A segment-list model predicts every output on every cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_encode_ir;

    typedef struct packed {
        logic       ir_out;
        logic       ir_led;
        logic       busy;
        logic       done;
        logic [2:0] led;
    } exp_t;

    typedef struct {
        int lm, ls, rs, bm, zs, os, g, div, hi;
    } tim_t;

    localparam exp_t c_idle_exp = '{ir_out: 1'b1, ir_led: 1'b0, busy: 1'b0, done: 1'b0, led: 3'd0};

    logic        clk = 1'b0;
    logic        tb_rst_n [2];
    logic        tb_send  [2];
    logic        tb_rep   [2];
    logic [31:0] tb_data  [2];
    exp_t        act_arr  [2];
    exp_t        exp_arr  [2];

    int n_checks = 0;
    int n_errors = 0;
    int q_runs[$];
    int q_dones;

    always #5 clk = ~clk;

    function automatic tim_t tim_of(int i);
        tim_t t;
        if (i == 0) begin
            t = '{lm: 9000, ls: 4500, rs: 2250, bm: 562, zs: 562, os: 1687, g: 6000, div: 26, hi: 9};
        end else begin
            t = '{lm: 40, ls: 20, rs: 10, bm: 3, zs: 3, os: 8, g: 30, div: 5, hi: 2};
        end
        return t;
    endfunction

    // Number of state cycles from the first leader cycle to the end of GUARD.
    function automatic int frame_len(tim_t t, bit rep, logic [31:0] d);
        int n;
        n = t.lm + (rep ? t.rs : t.ls) + t.bm + t.g;
        if (!rep) begin
            for (int b = 0; b < 32; b++) begin
                n += t.bm + (d[b] ? t.os : t.zs);
            end
        end
        return n;
    endfunction

    // Expected outputs for state cycle sc of a frame: walk the segment list.
    function automatic exp_t model_out(tim_t t, bit active, bit rep, logic [31:0] d, int sc);
        exp_t       e;
        int         len [68];
        logic [2:0] code[68];
        int         n;
        int         off;
        bit         mark;
        e = c_idle_exp;
        if (!active) return e;
        n = 0;
        code[n] = 3'd1; len[n] = t.lm;                n++;
        code[n] = 3'd2; len[n] = rep ? t.rs : t.ls;   n++;
        if (!rep) begin
            for (int b = 31; b >= 0; b--) begin
                code[n] = 3'd3; len[n] = t.bm;                  n++;
                code[n] = 3'd4; len[n] = d[b] ? t.os : t.zs;    n++;
            end
        end
        code[n] = 3'd5; len[n] = t.bm; n++;
        code[n] = 3'd6; len[n] = t.g;  n++;
        off = sc;
        for (int k = 0; k < n; k++) begin
            if (off < len[k]) begin
                mark     = (code[k] == 3'd1) || (code[k] == 3'd3) || (code[k] == 3'd5);
                e.ir_out = !mark;
                e.ir_led = mark && ((off % t.div) < t.hi);
                e.busy   = 1'b1;
                e.led    = code[k];
                return e;
            end
            off -= len[k];
        end
        if (off == 0) e.done = 1'b1;
        return e;
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        encode_ir_if u_if ();

        assign u_if.data = tb_data[gi];
        assign u_if.send = tb_send[gi];
        assign u_if.rep  = tb_rep[gi];

        encode_ir #(
            .T_LEAD_MARK  (gi == 0 ? 9000 : 40),
            .T_LEAD_SPACE (gi == 0 ? 4500 : 20),
            .T_REP_SPACE  (gi == 0 ? 2250 : 10),
            .T_BIT_MARK   (gi == 0 ? 562  : 3),
            .T_ZERO_SPACE (gi == 0 ? 562  : 3),
            .T_ONE_SPACE  (gi == 0 ? 1687 : 8),
            .T_GUARD      (gi == 0 ? 6000 : 30),
            .CARRIER_DIV  (gi == 0 ? 26   : 5),
            .CARRIER_HIGH (gi == 0 ? 9    : 2)
        ) u_dut (
            .clk   (clk),
            .rst_n (tb_rst_n[gi]),
            .bus   (u_if)
        );

        assign act_arr[gi] = {u_if.ir_out, u_if.ir_led, u_if.busy, u_if.done, u_if.led};

        exp_t        m_exp;
        bit          m_active;
        bit          m_rep;
        logic [31:0] m_data;
        int          m_sc;

        always @(posedge clk or negedge tb_rst_n[gi]) begin
            if (!tb_rst_n[gi]) begin
                m_exp    <= c_idle_exp;
                m_active <= 1'b0;
                m_rep    <= 1'b0;
                m_data   <= 32'd0;
                m_sc     <= 0;
            end else begin
                m_exp <= model_out(tim_of(gi), m_active, m_rep, m_data, m_sc);
                if ((!m_active || (m_sc >= frame_len(tim_of(gi), m_rep, m_data))) &&
                    (tb_send[gi] || tb_rep[gi])) begin
                    m_active <= 1'b1;
                    m_rep    <= !tb_send[gi];
                    m_data   <= tb_data[gi];
                    m_sc     <= 0;
                end else if (m_active) begin
                    m_sc <= m_sc + 1;
                end
            end
        end

        assign exp_arr[gi] = m_exp;
    end

    // Cycle-by-cycle comparison of both instances against the model.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (act_arr[i] !== exp_arr[i]) begin
                    n_errors++;
                    $display("FAIL cycle_outputs inst%0d t=%0t got ir_out=%b ir_led=%b busy=%b done=%b led=%0d expected ir_out=%b ir_led=%b busy=%b done=%b led=%0d",
                             i, $time, act_arr[i].ir_out, act_arr[i].ir_led, act_arr[i].busy,
                             act_arr[i].done, act_arr[i].led, exp_arr[i].ir_out, exp_arr[i].ir_led,
                             exp_arr[i].busy, exp_arr[i].done, exp_arr[i].led);
                end
            end
        end
    end

    task automatic check_int(input string name, input int a, input int e);
        n_checks++;
        if (a !== e) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, a, e);
        end
    endtask

    task automatic check_hex(input string name, input logic [31:0] a, input logic [31:0] e);
        n_checks++;
        if (a !== e) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, a, e);
        end
    endtask

    // Issue one request and record ir_out run lengths up to the first done.
    task automatic run_frame(input int i, input bit s, input bit r, input logic [31:0] d,
                             input int bound, input bit poke);
        bit   started;
        logic cur;
        int   len;
        q_runs.delete();
        q_dones = 0;
        started = 1'b0;
        cur     = 1'b1;
        len     = 0;
        @(negedge clk);
        tb_data[i] = d;
        tb_send[i] = s;
        tb_rep[i]  = r;
        @(negedge clk);
        tb_send[i] = 1'b0;
        tb_rep[i]  = 1'b0;
        for (int c = 0; c < bound; c++) begin
            @(negedge clk);
            if (poke && (c == 2))  tb_data[i] = ~d;
            if (poke && (c == 30)) tb_send[i] = 1'b1;
            if (poke && (c == 31)) tb_send[i] = 1'b0;
            if (act_arr[i].done) begin
                q_dones++;
                if (q_dones == 1) q_runs.push_back(len);
            end else if (q_dones == 0) begin
                if (!started) begin
                    if (act_arr[i].ir_out == 1'b0) begin
                        started = 1'b1;
                        cur     = 1'b0;
                        len     = 1;
                    end
                end else if (act_arr[i].ir_out == cur) begin
                    len++;
                end else begin
                    q_runs.push_back(len);
                    cur = act_arr[i].ir_out;
                    len = 1;
                end
            end
        end
    endtask

    function automatic int span_of_runs();
        int s = 0;
        for (int k = 0; k + 1 < q_runs.size(); k++) s += q_runs[k];
        return s;
    endfunction

    function automatic logic [31:0] decode_runs(tim_t t);
        logic [31:0] w = 'x;
        if (q_runs.size() == 68) begin
            for (int b = 0; b < 32; b++) begin
                w = {w[30:0], (2 * q_runs[3 + 2 * b] > t.zs + t.os)};
            end
        end
        return w;
    endfunction

    task automatic data_frame(input string name, input logic [31:0] d, input bit both,
                              input bit poke, input int span);
        run_frame(1, 1'b1, both, d, 480, poke);
        check_int({name, "_runs"}, q_runs.size(), 68);
        check_int({name, "_dones"}, q_dones, 1);
        check_int({name, "_span"}, span_of_runs(), span);
        if (q_runs.size() == 68) begin
            check_int({name, "_lead_low"}, q_runs[0], 40);
            check_int({name, "_lead_high"}, q_runs[1], 20);
            check_int({name, "_guard"}, q_runs[67], 30);
        end
        check_hex({name, "_word"}, decode_runs(tim_of(1)), d);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            tb_rst_n[i] = 1'b0;
            tb_send[i]  = 1'b0;
            tb_rep[i]   = 1'b0;
            tb_data[i]  = 32'd0;
        end

        // The model's own arithmetic against the quoted NEC frame spans.
        check_int("model_span_00ffa55a", frame_len(tim_of(0), 1'b0, 32'h00FFA55A) - 6000, 68030);
        check_int("model_span_zero",     frame_len(tim_of(0), 1'b0, 32'h00000000) - 6000, 50030);
        check_int("model_span_ones",     frame_len(tim_of(0), 1'b0, 32'hFFFFFFFF) - 6000, 86030);
        check_int("model_span_repeat",   frame_len(tim_of(0), 1'b1, 32'h0) - 6000, 11812);

        repeat (4) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check_int("reset_hold", int'(act_arr[i]), int'(c_idle_exp));
        end
        tb_rst_n[0] = 1'b1;
        tb_rst_n[1] = 1'b1;
        repeat (3) @(negedge clk);

        // Real-timing repeat frame.
        run_frame(0, 1'b0, 1'b1, 32'hDEADBEEF, 17830, 1'b0);
        check_int("rep_runs", q_runs.size(), 4);
        check_int("rep_dones", q_dones, 1);
        if (q_runs.size() == 4) begin
            check_int("rep_lead_low", q_runs[0], 9000);
            check_int("rep_lead_high", q_runs[1], 2250);
            check_int("rep_stop_low", q_runs[2], 562);
            check_int("rep_guard", q_runs[3], 6000);
        end

        // Real-timing data frame cut by reset at cycle 20000.
        @(negedge clk);
        tb_data[0] = 32'hA0F0F0F0;
        tb_send[0] = 1'b1;
        @(negedge clk);
        tb_send[0] = 1'b0;
        repeat (20000) @(negedge clk);
        check_int("busy_mid_frame", int'(act_arr[0].busy), 1);
        #2;
        tb_rst_n[0] = 1'b0;
        #1;
        check_int("async_reset_outputs", int'(act_arr[0]), int'(c_idle_exp));
        repeat (3) @(negedge clk);
        tb_rst_n[0] = 1'b1;
        begin
            int lows = 0;
            for (int c = 0; c < 60; c++) begin
                @(negedge clk);
                if (act_arr[0].ir_out == 1'b0 || act_arr[0].busy) lows++;
            end
            check_int("no_resume_after_reset", lows, 0);
        end

        // Shortened-timing data frames.
        data_frame("f_00ffa55a", 32'h00FFA55A, 1'b0, 1'b1, 335);
        data_frame("f_zero",     32'h00000000, 1'b0, 1'b0, 255);
        data_frame("f_ones",     32'hFFFFFFFF, 1'b0, 1'b0, 415);
        data_frame("f_both_req", 32'h12345678, 1'b1, 1'b0, 40 + 20 + 96 + 13 * 8 + 19 * 3 + 3);

        run_frame(1, 1'b0, 1'b1, 32'h0, 120, 1'b0);
        check_int("f_rep_runs", q_runs.size(), 4);
        if (q_runs.size() == 4) begin
            check_int("f_rep_lead_low", q_runs[0], 40);
            check_int("f_rep_lead_high", q_runs[1], 10);
            check_int("f_rep_stop_low", q_runs[2], 3);
            check_int("f_rep_guard", q_runs[3], 30);
        end

        // Held request: frames restart immediately after each done.
        begin
            int dn = 0;
            @(negedge clk);
            tb_data[1] = 32'h00000000;
            tb_send[1] = 1'b1;
            for (int c = 0; c < 600; c++) begin
                @(negedge clk);
                if (act_arr[1].done) dn++;
            end
            tb_send[1] = 1'b0;
            check_int("back_to_back_dones", dn, 2);
            repeat (320) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/encode_ir.md
# encode_ir

NEC pulse-distance IR transmitter. It serialises a 32-bit word, or a repeat code, into the NEC mark/space waveform that the team's IR decoder accepts. It drives two outputs:
- a demodulated active-low line (`ir_out`) for loopback into the decoder;
- a 38 kHz-modulated LED drive (`ir_led`).

The block sits between a host command interface and the IR emitter. All timing assumes `clk` = 1 MHz, so 1 cycle = 1 µs.

## Interface
- `T_LEAD_MARK`, 9000, leader mark length (cycles)
- `T_LEAD_SPACE`, 4500, leader space for a data frame
- `T_REP_SPACE`, 2250, leader space for a repeat frame
- `T_BIT_MARK`, 562, mark preceding every bit and the stop mark
- `T_ZERO_SPACE`, 562, space encoding logic 0
- `T_ONE_SPACE`, 1687, space encoding logic 1
- `T_GUARD`, 6000, forced idle-high time after the stop mark
- `CARRIER_DIV`, 26, carrier period in cycles (≈38 kHz)
- `CARRIER_HIGH`, 9, carrier high cycles per period (≈1/3 duty)
- `clk`  in  1  system clock, 1 MHz
- `rst_n`  in  1  asynchronous active-low reset
- `data`  in  32  frame payload, sampled on accept
- `send`  in  1  request a data frame (level, sampled in IDLE)
- `rep`  in  1  request a repeat frame (level, sampled in IDLE)
- `busy`  out  1  frame in progress
- `done`  out  1  one-cycle pulse at frame completion
- `ir_out`  out  1  demodulated line: 0 = mark, 1 = space/idle
- `ir_led`  out  1  modulated emitter drive
- `led`  out  3  current state encoding, for debug

## Operation

**State encoding.** IDLE=0, LEAD_MARK=1, LEAD_SPACE=2, BIT_MARK=3, BIT_SPACE=4, STOP_MARK=5, GUARD=6.

**Duration counter.**
- 14-bit, shared by all states.
- Cleared on every state entry; the state exits when the count reaches (duration−1).

**IDLE**
- Accepts a request only in IDLE.
- `send` has priority over `rep` when both are high.
- On `send`: latch `data` into a 32-bit shift register, clear the rep flag, go to LEAD_MARK.
- On `rep` alone: set the rep flag, go to LEAD_MARK.

**LEAD_MARK → LEAD_SPACE.** LEAD_SPACE length is `T_REP_SPACE` if the rep flag is set, otherwise `T_LEAD_SPACE`.
- Rep flag set: LEAD_SPACE goes to STOP_MARK.
- Rep flag clear: LEAD_SPACE goes to BIT_MARK with bit index = 0.

**Bit loop.**
- BIT_MARK (`T_BIT_MARK`) goes to BIT_SPACE.
- BIT_SPACE length is `T_ONE_SPACE` if the shift-register MSB is 1, otherwise `T_ZERO_SPACE`.
- On BIT_SPACE exit:
  - shift left by 1;
  - increment the 5-bit index;
  - after index 31, go to STOP_MARK; otherwise go to BIT_MARK.
- Bits are sent MSB first (`data[31]` first), so the decoder's left-shift reassembles the word unchanged.

**Completion.**
- STOP_MARK (`T_BIT_MARK`) goes to GUARD.
- GUARD (`T_GUARD`) goes to IDLE.
- GUARD exceeds the decoder's 5000-cycle trailing-high timeout, guaranteeing frame termination.

**Output rules.**
- `ir_out` = 0 in the LEAD_MARK, BIT_MARK and STOP_MARK states; 1 otherwise.
- Carrier counter resets to 0 on entry to any mark state and wraps at `CARRIER_DIV`−1.
- `ir_led` = 1 iff in a mark state and carrier count < `CARRIER_HIGH`. So every mark starts with a carrier high phase; `ir_led` = 0 outside marks.
- `busy` = 1 in every state except IDLE.
- `done` pulses for exactly one cycle, in the cycle the block re-enters IDLE from GUARD.
- `send`/`rep` asserted while busy are ignored; they are not queued.
- Changes on `data` after accept have no effect on the frame in flight.

## Timing
- All outputs are registered.
- Reset values: `ir_out`=1, `ir_led`=0, `busy`=0, `done`=0, `led`=0. Shift register, counters and rep flag are also 0.
- Reset asserted mid-frame forces all of the above immediately (asynchronously). After `rst_n` deasserts, no partial frame resumes.
- Accept at clock edge N (IDLE & request): `ir_out` first reads 0 and `busy` 1 after edge N+1.
- Each segment lasts exactly its parameter value in cycles, with no gaps between segments.
- Data-frame low-to-stop-end span = 9000 + 4500 + 32·562 + Σspaces + 562.
- Repeat-frame span = 9000 + 2250 + 562 = 11812 cycles.
- Back-to-back: a request held high continuously is re-accepted in the cycle after `done`, i.e. the first IDLE cycle.

## Test plan
- **Reset:** hold `rst_n`=0 → `ir_out`=1, `ir_led`=0, `busy`=0, `done`=0, `led`=0. Pulse reset at cycle 20000 of a frame → outputs return to these values in the same cycle; `ir_out` stays 1 afterwards.
- **Data frame 0x00FFA55A** (16 ones, 16 zeros) → leader low 9000, high 4500; total low-start to stop-mark-end = 68030 cycles. Loopback into the decoder yields `data`=0x00FFA55A and `load` pulsing after GUARD. `done` appears 6000 cycles after stop-mark end.
- **Repeat frame** → low 9000, high 2250, low 562, high 6000, then `done`. Decoder asserts `rep`; its `data` is unchanged.
- **Arbitration and busy:** `send`=`rep`=1 together → data frame (leader space 4500). A `send` pulse mid-frame → ignored; exactly one `done` results.
- **Carrier:** during any mark, `ir_led` is a repeating pattern of 9 high / 17 low cycles, starting high in the mark's first cycle; `ir_led`=0 throughout spaces and GUARD.
- **Edge data 0x00000000 and 0xFFFFFFFF** → frame spans 9000+4500+32·1124+562 = 50030 and 9000+4500+32·2249+562 = 86030 cycles respectively; decoder reproduces both words.
